// File: rtl/arp_req_sched.sv
// ARP engine sequencer: answers local ARP requests, learns bindings into the cache,
// and resolves queried IPs with broadcast requests, timeout and retry.
module arp_req_sched #(
    parameter int unsigned TIMEOUT     = 1250000,
    parameter int unsigned RETRY_COUNT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [47:0] local_mac,
    input  logic [31:0] local_ip,
    input  logic        s_frame_valid,
    output logic        s_frame_ready,
    input  logic [15:0] s_arp_oper,
    input  logic [47:0] s_arp_sha,
    input  logic [31:0] s_arp_spa,
    input  logic [31:0] s_arp_tpa,
    input  logic        s_query_valid,
    output logic        s_query_ready,
    input  logic [31:0] s_query_ip,
    output logic        m_frame_valid,
    input  logic        m_frame_ready,
    output logic [47:0] m_eth_dest_mac,
    output logic [15:0] m_arp_oper,
    output logic [47:0] m_arp_sha,
    output logic [31:0] m_arp_spa,
    output logic [47:0] m_arp_tha,
    output logic [31:0] m_arp_tpa,
    output logic        m_resp_valid,
    input  logic        m_resp_ready,
    output logic [31:0] m_resp_ip,
    output logic [47:0] m_resp_mac,
    output logic        m_resp_error,
    output logic        cache_wr_en,
    output logic [31:0] cache_wr_ip,
    output logic [47:0] cache_wr_mac,
    output logic        busy
);
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned RW = (RETRY_COUNT > 0) ? $clog2(RETRY_COUNT + 1) : 1;
    localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMEOUT - 1);
    localparam logic [RW-1:0] RETRY_MAX  = RW'(RETRY_COUNT);
    localparam logic [47:0]   BCAST_MAC  = 48'hFFFF_FFFF_FFFF;

    typedef enum logic [1:0] {IDLE, TX_REQ, WAIT} state_t;

    state_t      state, state_d;
    logic        reply_pend, reply_pend_d;
    logic [47:0] rp_sha, rp_sha_d;
    logic [31:0] rp_spa, rp_spa_d;
    logic [31:0] query_ip, query_ip_d;
    logic [TW-1:0] timer, timer_d;
    logic [RW-1:0] retry, retry_d;
    logic        m_frame_valid_d;
    logic [47:0] m_eth_dest_mac_d, m_arp_sha_d, m_arp_tha_d;
    logic [15:0] m_arp_oper_d;
    logic [31:0] m_arp_spa_d, m_arp_tpa_d;
    logic        m_resp_valid_d, m_resp_error_d;
    logic [31:0] m_resp_ip_d;
    logic [47:0] m_resp_mac_d;
    logic        cache_wr_en_d;
    logic [31:0] cache_wr_ip_d;
    logic [47:0] cache_wr_mac_d;
    logic        busy_d;

    logic frame_acc, query_acc, spa_nz, rx_local_req, match, tx_free, req_go;
    logic ld_reply, ld_req;

    assign s_frame_ready = rst_n && !reply_pend;
    assign s_query_ready = rst_n && (state == IDLE) && !m_resp_valid;

    assign frame_acc    = s_frame_valid && s_frame_ready;
    assign query_acc    = s_query_valid && s_query_ready;
    assign spa_nz       = (s_arp_spa != 32'd0);
    assign rx_local_req = frame_acc && (s_arp_oper == 16'd1) && (s_arp_tpa == local_ip) && spa_nz;
    assign match        = frame_acc && (state != IDLE) && (s_arp_spa == query_ip);
    assign tx_free      = !m_frame_valid || m_frame_ready;
    // A fresh query may launch its request in its own acceptance cycle.
    assign req_go       = ((state == TX_REQ) && !match) || query_acc;
    assign ld_reply     = tx_free && (reply_pend || rx_local_req);
    assign ld_req       = tx_free && !ld_reply && req_go;

    always_comb begin
        state_d          = state;
        reply_pend_d     = reply_pend;
        rp_sha_d         = rp_sha;
        rp_spa_d         = rp_spa;
        query_ip_d       = query_ip;
        timer_d          = timer;
        retry_d          = retry;
        m_frame_valid_d  = m_frame_valid;
        m_eth_dest_mac_d = m_eth_dest_mac;
        m_arp_oper_d     = m_arp_oper;
        m_arp_sha_d      = m_arp_sha;
        m_arp_spa_d      = m_arp_spa;
        m_arp_tha_d      = m_arp_tha;
        m_arp_tpa_d      = m_arp_tpa;
        m_resp_valid_d   = m_resp_valid;
        m_resp_ip_d      = m_resp_ip;
        m_resp_mac_d     = m_resp_mac;
        m_resp_error_d   = m_resp_error;
        cache_wr_en_d    = 1'b0;
        cache_wr_ip_d    = cache_wr_ip;
        cache_wr_mac_d   = cache_wr_mac;

        if (m_frame_valid && m_frame_ready) m_frame_valid_d = 1'b0;
        if (m_resp_valid && m_resp_ready)   m_resp_valid_d  = 1'b0;

        if (frame_acc && spa_nz) begin
            cache_wr_en_d  = 1'b1;
            cache_wr_ip_d  = s_arp_spa;
            cache_wr_mac_d = s_arp_sha;
        end

        // Resolution: an answer beats a timer expiry in the same cycle.
        if (match) begin
            m_resp_valid_d = 1'b1;
            m_resp_ip_d    = query_ip;
            m_resp_mac_d   = s_arp_sha;
            m_resp_error_d = 1'b0;
            state_d        = IDLE;
        end else if (state == WAIT) begin
            if (timer == '0) begin
                if (retry < RETRY_MAX) begin
                    retry_d = retry + RW'(1);
                    state_d = TX_REQ;
                end else begin
                    m_resp_valid_d = 1'b1;
                    m_resp_ip_d    = query_ip;
                    m_resp_mac_d   = 48'd0;
                    m_resp_error_d = 1'b1;
                    state_d        = IDLE;
                end
            end else begin
                timer_d = timer - TW'(1);
            end
        end

        if (query_acc) begin
            query_ip_d = s_query_ip;
            retry_d    = '0;
            state_d    = TX_REQ;
        end

        // TX register: replies first, then the outstanding request.
        if (ld_reply) begin
            m_frame_valid_d  = 1'b1;
            m_arp_oper_d     = 16'd2;
            m_eth_dest_mac_d = reply_pend ? rp_sha : s_arp_sha;
            m_arp_tha_d      = reply_pend ? rp_sha : s_arp_sha;
            m_arp_tpa_d      = reply_pend ? rp_spa : s_arp_spa;
            m_arp_sha_d      = local_mac;
            m_arp_spa_d      = local_ip;
            reply_pend_d     = 1'b0;
        end else if (ld_req) begin
            m_frame_valid_d  = 1'b1;
            m_arp_oper_d     = 16'd1;
            m_eth_dest_mac_d = BCAST_MAC;
            m_arp_tha_d      = 48'd0;
            m_arp_tpa_d      = query_acc ? s_query_ip : query_ip;
            m_arp_sha_d      = local_mac;
            m_arp_spa_d      = local_ip;
            state_d          = WAIT;
            timer_d          = TIMER_LOAD;
        end

        if (rx_local_req && !tx_free) begin
            reply_pend_d = 1'b1;
            rp_sha_d     = s_arp_sha;
            rp_spa_d     = s_arp_spa;
        end

        busy_d = (state_d != IDLE) || reply_pend_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            reply_pend     <= 1'b0;
            rp_sha         <= 48'd0;
            rp_spa         <= 32'd0;
            query_ip       <= 32'd0;
            timer          <= '0;
            retry          <= '0;
            m_frame_valid  <= 1'b0;
            m_eth_dest_mac <= 48'd0;
            m_arp_oper     <= 16'd0;
            m_arp_sha      <= 48'd0;
            m_arp_spa      <= 32'd0;
            m_arp_tha      <= 48'd0;
            m_arp_tpa      <= 32'd0;
            m_resp_valid   <= 1'b0;
            m_resp_ip      <= 32'd0;
            m_resp_mac     <= 48'd0;
            m_resp_error   <= 1'b0;
            cache_wr_en    <= 1'b0;
            cache_wr_ip    <= 32'd0;
            cache_wr_mac   <= 48'd0;
            busy           <= 1'b0;
        end else begin
            state          <= state_d;
            reply_pend     <= reply_pend_d;
            rp_sha         <= rp_sha_d;
            rp_spa         <= rp_spa_d;
            query_ip       <= query_ip_d;
            timer          <= timer_d;
            retry          <= retry_d;
            m_frame_valid  <= m_frame_valid_d;
            m_eth_dest_mac <= m_eth_dest_mac_d;
            m_arp_oper     <= m_arp_oper_d;
            m_arp_sha      <= m_arp_sha_d;
            m_arp_spa      <= m_arp_spa_d;
            m_arp_tha      <= m_arp_tha_d;
            m_arp_tpa      <= m_arp_tpa_d;
            m_resp_valid   <= m_resp_valid_d;
            m_resp_ip      <= m_resp_ip_d;
            m_resp_mac     <= m_resp_mac_d;
            m_resp_error   <= m_resp_error_d;
            cache_wr_en    <= cache_wr_en_d;
            cache_wr_ip    <= cache_wr_ip_d;
            cache_wr_mac   <= cache_wr_mac_d;
            busy           <= busy_d;
        end
    end

endmodule
